// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl
// Load/store controller for the 4K x 32 single-port data BSRAM (bypass read,
// write-through write, no byte enables). Sub-word stores use read-modify-write.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   req_*             : LSU request (valid/ready, we, byte addr, wstrb, wdata)
//   rsp_*             : response (valid/ready, rdata = load data or merged word)
//   ram_ce/oce/wre    : RAM control pins
//   ram_reset         : RAM reset pin (follows reset)
//   ram_ad/din/dout   : RAM word address, write data, read data
//
// Build option
//   DMEM_CTRL_RDBYPASS_EN : load data is presented combinationally from ram_dout
//                           in RD_WAIT, cutting load latency by one cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; RAM pins follow the incoming request
// RD_WAIT | load read issued, ram_dout valid this cycle
// MERGE   | sub-word store: merge old word with lanes, write it back
// RSP     | response held until rsp_ready

module dmem_rmw_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_wstrb,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-3:0] ram_ad,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        MERGE   = 2'd2,
        RSP     = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-3:0] ad_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              valid_q;
    logic [31:0]       merged;
    logic              accept;

    // Byte-offset bits carry no meaning for a word-wide RAM.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

    always_comb begin
        merged = ram_dout;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // RAM pins are combinational so the access lands in the accept cycle.
    // Reset gates everything, which is what drops an interrupted MERGE write.
    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = '0;
        ram_din = '0;
        if (!reset) begin
            if (accept) begin
                if (!(req_we && (req_wstrb == 4'h0))) begin
                    ram_ce = 1'b1;
                    ram_ad = req_addr[ADDR_W-1:2];
                    if (req_we && (req_wstrb == 4'hF)) begin
                        ram_wre = 1'b1;
                        ram_din = req_wdata;
                    end
                end
            end else if (state == MERGE) begin
                ram_ce  = 1'b1;
                ram_wre = 1'b1;
                ram_ad  = ad_q;
                ram_din = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            rdata_q <= '0;
            ad_q    <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ad_q    <= req_addr[ADDR_W-1:2];
                        wstrb_q <= req_wstrb;
                        wdata_q <= req_wdata;
                        if (!req_we) begin
                            state <= RD_WAIT;
                        end else if (req_wstrb == 4'hF) begin
                            rdata_q <= req_wdata;
                            valid_q <= 1'b1;
                            state   <= RSP;
                        end else if (req_wstrb == 4'h0) begin
                            rdata_q <= '0;
                            valid_q <= 1'b1;
                            state   <= RSP;
                        end else begin
                            state <= MERGE;
                        end
                    end
                end
                RD_WAIT: begin
                    rdata_q <= ram_dout;
`ifdef DMEM_CTRL_RDBYPASS_EN
                    if (rsp_ready) begin
                        state <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                        state   <= RSP;
                    end
`else
                    valid_q <= 1'b1;
                    state   <= RSP;
`endif
                end
                MERGE: begin
                    rdata_q <= merged;
                    valid_q <= 1'b1;
                    state   <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_CTRL_RDBYPASS_EN
    logic bypass_now;
    assign bypass_now = !reset && (state == RD_WAIT);
    assign rsp_valid  = valid_q || bypass_now;
    assign rsp_rdata  = bypass_now ? ram_dout : rdata_q;
`else
    assign rsp_valid  = valid_q;
    assign rsp_rdata  = rdata_q;
`endif

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: RAM behavioural model, request driver, and a
// response monitor that pops expected data/cycle from a scoreboard queue.
module tb_dmem_rmw_ctrl;

    localparam int ADDR_W = 14;
`ifdef DMEM_CTRL_RDBYPASS_EN
    localparam int LD_LAT = 1;
`else
    localparam int LD_LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [3:0]        req_wstrb = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              ram_ce, ram_oce, ram_wre, ram_reset;
    logic [ADDR_W-3:0] ram_ad;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_reset(ram_reset), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model: read data appears the cycle after ce, writes show through.
    logic [31:0] mem [0:4095];
    int cyc = 0;
    int ce_cnt = 0, wr_cnt = 0, wr_cyc = -1;
    logic [ADDR_W-3:0] wr_ad = '0;
    logic [31:0] wr_din = '0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        ram_dout = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_ce) begin
            ce_cnt++;
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
                wr_cnt++;
                wr_cyc = cyc;
                wr_ad  = ram_ad;
                wr_din = ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
        cyc++;
    end

    // Scoreboard
    logic [31:0] exp_data_q [$];
    int          exp_cyc_q  [$];
    logic        prev_valid = 1'b0;
    logic [31:0] prev_rdata = '0;
    int          hs_cyc = -1;

    always @(negedge clk) begin
        if (rsp_valid && !prev_valid) begin
            if (exp_data_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h at cycle %0d with nothing pending",
                         rsp_rdata, cyc);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_data_q.pop_front());
                chk("rsp_cycle", cyc, exp_cyc_q.pop_front());
            end
        end else if (rsp_valid && prev_valid) begin
            chk("rsp_rdata_stable", rsp_rdata, prev_rdata);
        end
        if (rsp_valid && rsp_ready) hs_cyc = cyc;
        prev_valid = rsp_valid;
        prev_rdata = rsp_rdata;
    end

    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] strb, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int lat,
                         input bit expect_rsp, output int t_acc);
        int i;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wd;
        req_valid = 1'b1;
        i = 0;
        while (!req_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: req_ready low for 100 cycles, addr 0x%04h", addr);
            req_valid = 1'b0;
            t_acc = -1;
        end else begin
            t_acc = cyc;
            if (expect_rsp) begin
                exp_data_q.push_back(exp_rd);
                exp_cyc_q.push_back(cyc + lat);
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (!(exp_data_q.size() == 0 && !rsp_valid && req_ready) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: pending=%0d rsp_valid=%0b", exp_data_q.size(), rsp_valid);
        end
    endtask

    initial begin
        int t, t2, snap_ce, snap_wr;

        // Reset with a request pending: it must not be taken.
        req_valid = 1'b1;
        req_we    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_ram_ce", ram_ce, 0);
        chk("reset_ram_reset", ram_reset, 1);
        chk("ram_oce", ram_oce, 1);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_no_access", ce_cnt, 0);

        // Full-word store then load
        issue(1, 14'h0010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, t);
        chk("fw_wr_cycle", wr_cyc, t);
        chk("fw_wr_ad", wr_ad, 12'h004);
        issue(0, 14'h0010, 4'h0, 32'h0, 32'hDEADBEEF, LD_LAT, 1, t);
        wait_idle();

        // Sub-word store: lane 0 into 0x11223344
        issue(1, 14'h0020, 4'hF, 32'h11223344, 32'h11223344, 1, 1, t);
        issue(1, 14'h0020, 4'b0001, 32'h000000AA, 32'h112233AA, 2, 1, t);
        wait_idle();
        chk("rmw_wr_cycle", wr_cyc, t + 1);
        chk("rmw_wr_din", wr_din, 32'h112233AA);
        chk("rmw_wr_ad", wr_ad, 12'h008);
        issue(0, 14'h0020, 4'h0, 32'h0, 32'h112233AA, LD_LAT, 1, t);
        wait_idle();

        // No-lane store: no RAM access, rdata 0
        issue(1, 14'h0030, 4'hF, 32'h55555555, 32'h55555555, 1, 1, t);
        wait_idle();
        snap_ce = ce_cnt;
        issue(1, 14'h0030, 4'h0, 32'hFFFFFFFF, 32'h0, 1, 1, t);
        wait_idle();
        chk("nolane_no_ce", ce_cnt, snap_ce);
        issue(0, 14'h0030, 4'h0, 32'h0, 32'h55555555, LD_LAT, 1, t);
        wait_idle();

        // Load with the consumer stalled for 5 cycles
        rsp_ready = 1'b0;
        issue(0, 14'h0010, 4'h0, 32'h0, 32'hDEADBEEF, LD_LAT, 1, t);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        issue(1, 14'h0050, 4'hF, 32'h0BADCAFE, 32'h0BADCAFE, 1, 1, t2);
        chk("after_hs_accept", (t2 > hs_cyc) && (hs_cyc > t), 1);
        wait_idle();

        // Reset during MERGE: write must be dropped
        issue(1, 14'h0040, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, t);
        wait_idle();
        snap_wr = wr_cnt;
        issue(1, 14'h0040, 4'b0010, 32'h0000BB00, 32'h0, 0, 0, t);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_merge_ce", ram_ce, 0);
        chk("rst_merge_wre", ram_wre, 0);
        @(negedge clk);
        chk("rst_merge_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_merge_idle", req_ready, 1);
        chk("rst_merge_no_write", wr_cnt, snap_wr);
        issue(0, 14'h0040, 4'h0, 32'h0, 32'hCAFEF00D, LD_LAT, 1, t);
        wait_idle();

        // Back-to-back at the top and bottom word
        issue(1, 14'h3FFC, 4'hF, 32'h0FFFA5A5, 32'h0FFFA5A5, 1, 1, t);
        chk("top_wr_ad", wr_ad, 12'hFFF);
        issue(1, 14'h0000, 4'hF, 32'h12345678, 32'h12345678, 1, 1, t);
        chk("bot_wr_ad", wr_ad, 12'h000);
        issue(0, 14'h3FFC, 4'h0, 32'h0, 32'h0FFFA5A5, LD_LAT, 1, t);
        issue(0, 14'h0000, 4'h0, 32'h0, 32'h12345678, LD_LAT, 1, t);
        issue(1, 14'h3FFE, 4'b1100, 32'h77660000, 32'h7766A5A5, 2, 1, t);
        issue(0, 14'h3FFC, 4'h0, 32'h0, 32'h7766A5A5, LD_LAT, 1, t);
        wait_idle();

        chk("scoreboard_empty", exp_data_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
